// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the datapath/memory side.
// The master modport is the control unit; the slave modport is the datapath.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             mem_ready;

  logic             pc_write;
  logic             pc_write_cond;
  logic             pc_source;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_write;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       ALUop;
  logic             halted;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state;

  modport master (
    input  opcode, funct3, funct7, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, ALUop,
           halted, instret, state
  );

  modport slave (
    output opcode, funct3, funct7, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, ALUop,
           halted, instret, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RISC-V core: sequences fetch/decode/execute/
// memory/writeback, handshakes a variable-latency memory and counts retirements.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master ctrl_if
);

  localparam int unsigned OP_W = 7;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
  } state_e;

  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             rtype_legal;
  logic             retire;

  // Only R-type encodings the ALU control decoder supports may reach EXEC.
  always_comb begin
    rtype_legal = 1'b0;
    case (ctrl_if.funct3)
      3'b000:                 rtype_legal = (ctrl_if.funct7 == 7'b0000000) ||
                                            (ctrl_if.funct7 == 7'b0100000);
      3'b100, 3'b110, 3'b111: rtype_legal = (ctrl_if.funct7 == 7'b0000000);
      default:                rtype_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (ctrl_if.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl_if.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = rtype_legal ? S_EXEC : S_TRAP;
          OP_BRANCH:         state_d = (ctrl_if.funct3 == 3'b000) ? S_BRANCH : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (ctrl_if.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (ctrl_if.mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (ctrl_if.mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_RESET;
    endcase
  end

  // Per-state control word; registered against state_d so it always tracks state_q.
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
      S_TRAP:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb ctrl_d = decode_ctrl(state_d);

  // Last cycle of each retiring instruction; trapped instructions never get here.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BRANCH: retire = 1'b1;
      S_MEMWR:                    retire = ctrl_if.mem_ready;
      default:                    retire = 1'b0;
    endcase
  end

  always_comb instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      ctrl_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      instret_q <= instret_d;
    end
  end

  // IR and PC load on the very cycle the fetch read completes.
  assign ctrl_if.ir_write      = (state_q == S_FETCH) && ctrl_if.mem_ready;
  assign ctrl_if.pc_write      = (state_q == S_FETCH) && ctrl_if.mem_ready;
  assign ctrl_if.pc_write_cond = ctrl_q.pc_write_cond;
  assign ctrl_if.pc_source     = ctrl_q.pc_source;
  assign ctrl_if.i_or_d        = ctrl_q.i_or_d;
  assign ctrl_if.mem_read      = ctrl_q.mem_read;
  assign ctrl_if.mem_write     = ctrl_q.mem_write;
  assign ctrl_if.reg_write     = ctrl_q.reg_write;
  assign ctrl_if.mem_to_reg    = ctrl_q.mem_to_reg;
  assign ctrl_if.alu_src_a     = ctrl_q.alu_src_a;
  assign ctrl_if.alu_src_b     = ctrl_q.alu_src_b;
  assign ctrl_if.ALUop         = ctrl_q.alu_op;
  assign ctrl_if.halted        = ctrl_q.halted;
  assign ctrl_if.instret       = instret_q;
  assign ctrl_if.state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle vectors with a scoreboard
// of expected state/control/instret, plus reset, trap and counter-wrap sequences.
module tb_multicycle_control;

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] S_RESET  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_TRAP   = 4'd10;

  localparam logic [31:0] I_SUB  = 32'h40208033;
  localparam logic [31:0] I_LW   = 32'h0000a083;
  localparam logic [31:0] I_SW   = 32'h0020a023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_MUL  = 32'h02208033;
  localparam logic [31:0] I_ADDI = 32'h00100093;

  // {pw, pwc, ps, iod, mr, mw, irw, rw, m2r, asa, asb[1:0], aluop[1:0], halted}
  typedef logic [14:0] ctl_t;

  typedef struct {
    logic        ready;
    logic [31:0] instr;
    logic [3:0]  st;
    logic [3:0]  cnt;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    logic [3:0] cnt;
    ctl_t       ctl;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb[$];
  vec_t vecs[$];

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic ctl_t exp_ctl(input logic [3:0] st, input logic rdy);
    logic pw, pwc, ps, iod, mr, mw, irw, rw, m2r, asa, h;
    logic [1:0] asb, op;
    {pw, pwc, ps, iod, mr, mw, irw, rw, m2r, asa, h} = '0;
    asb = 2'b00;
    op  = 2'b00;
    case (st)
      S_FETCH:  begin mr = 1'b1; asb = 2'b01; pw = rdy; irw = rdy; end
      S_DECODE: asb = 2'b11;
      S_MEMADR: begin asa = 1'b1; asb = 2'b10; end
      S_MEMRD:  begin mr = 1'b1; iod = 1'b1; end
      S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      S_MEMWR:  begin mw = 1'b1; iod = 1'b1; end
      S_EXEC:   begin asa = 1'b1; op = 2'b10; end
      S_ALUWB:  rw = 1'b1;
      S_BRANCH: begin asa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 1'b1; end
      S_TRAP:   h = 1'b1;
      default:  h = 1'b0;
    endcase
    return {pw, pwc, ps, iod, mr, mw, irw, rw, m2r, asa, asb, op, h};
  endfunction

  function automatic ctl_t act_ctl();
    return {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d,
            bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write,
            bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.ALUop, bus.halted};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  // One clock cycle: drive at the falling edge, expect pushed, then popped and compared.
  task automatic step(input logic rdy, input logic [31:0] instr,
                      input logic [3:0] st, input logic [3:0] cnt);
    exp_t e;
    @(negedge clk);
    bus.mem_ready = rdy;
    bus.opcode    = instr[6:0];
    bus.funct3    = instr[14:12];
    bus.funct7    = instr[31:25];
    sb.push_back('{st: st, cnt: cnt, ctl: exp_ctl(st, rdy)});
    #1;
    e = sb.pop_front();
    check("state",   32'(bus.state),   32'(e.st));
    check("ctrl",    32'(act_ctl()),   32'(e.ctl));
    check("instret", 32'(bus.instret), 32'(e.cnt));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input logic rdy, input logic [31:0] instr,
                     input logic [3:0] st, input logic [3:0] cnt);
    vecs.push_back('{ready: rdy, instr: instr, st: st, cnt: cnt});
  endtask

  initial begin
    logic [3:0] cnt;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = '0;
    bus.funct3    = '0;
    bus.funct7    = '0;

    // R-type sub, zero-wait: 4 cycles
    add(1, I_SUB, S_FETCH,  0); add(1, I_SUB, S_DECODE, 0);
    add(0, I_SUB, S_EXEC,   0); add(1, I_SUB, S_ALUWB,  0);
    // lw with two wait cycles in MEMRD: 7 cycles
    add(1, I_LW, S_FETCH,  1); add(1, I_LW, S_DECODE, 1); add(0, I_LW, S_MEMADR, 1);
    add(0, I_LW, S_MEMRD,  1); add(0, I_LW, S_MEMRD,  1); add(1, I_LW, S_MEMRD,  1);
    add(1, I_LW, S_MEMWB,  1);
    // beq with one fetch wait
    add(0, I_BEQ, S_FETCH, 2); add(1, I_BEQ, S_FETCH, 2);
    add(0, I_BEQ, S_DECODE, 2); add(1, I_BEQ, S_BRANCH, 2);
    // sw with one wait in MEMWR
    add(1, I_SW, S_FETCH,  3); add(0, I_SW, S_DECODE, 3); add(1, I_SW, S_MEMADR, 3);
    add(0, I_SW, S_MEMWR,  3); add(1, I_SW, S_MEMWR,  3);
    add(1, I_SUB, S_FETCH, 4);

    // reset values, checked while rst_n is still low
    @(negedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1;
    check("rst_state",   32'(bus.state),   32'(S_RESET));
    check("rst_ctrl",    32'(act_ctl()),   32'(ctl_t'(0)));
    check("rst_instret", 32'(bus.instret), 32'(0));
    rst_n = 1'b1;

    foreach (vecs[i]) step(vecs[i].ready, vecs[i].instr, vecs[i].st, vecs[i].cnt);

    // reset pulsed mid-store while waiting on memory
    step(1, I_SW, S_DECODE, 4);
    step(1, I_SW, S_MEMADR, 4);
    step(0, I_SW, S_MEMWR,  4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state",   32'(bus.state),   32'(S_RESET));
    check("async_ctrl",    32'(act_ctl()),   32'(ctl_t'(0)));
    check("async_instret", 32'(bus.instret), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step(1, I_BEQ, S_FETCH,  0);
    step(1, I_BEQ, S_DECODE, 0);
    step(1, I_BEQ, S_BRANCH, 0);

    // illegal R-type traps; halted sticky, mem_ready pulses ignored, count frozen
    step(1, I_MUL, S_FETCH,  1);
    step(1, I_MUL, S_DECODE, 1);
    step(0, I_MUL, S_TRAP,   1);
    step(1, I_MUL, S_TRAP,   1);
    step(1, I_SUB, S_TRAP,   1);
    step(0, I_SUB, S_TRAP,   1);

    // unsupported opcode after a fresh reset
    pulse_reset();
    step(1, I_ADDI, S_FETCH,  0);
    step(1, I_ADDI, S_DECODE, 0);
    step(1, I_ADDI, S_TRAP,   0);
    step(1, I_ADDI, S_TRAP,   0);

    // counter wraps after 16 retirements at CNT_W=4
    pulse_reset();
    cnt = 4'd0;
    for (int n = 0; n < 16; n++) begin
      step(1, I_BEQ, S_FETCH,  cnt);
      step(0, I_BEQ, S_DECODE, cnt);
      step(1, I_BEQ, S_BRANCH, cnt);
      cnt = cnt + 4'd1;
    end
    step(0, I_BEQ, S_FETCH, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
